demux8x1_deser: RTL
===================

# demux8x1_deser

Sequential 1-to-8 demultiplexer that routes a serial bit stream into the eight slots of a parallel word. It is the receiving end of a serializer built on `mux8x1`, where a 3-bit select walks D[0..7] onto Y. Each accepted bit is written to a slot chosen by an internal counter, or optionally by an external select. A completed word is presented on Y with a valid/ready handshake.

## Interface
Parameters:
- MSB_FIRST, default 0: 0 = first serial bit lands in Y[0]; 1 = first bit lands in Y[7].

Ports:
- clk  in  1  rising-edge clock; sole clock domain.
- rst  in  1  reset, synchronous, active-high.
- D  in  1  serial data bit.
- DV  in  1  D valid; a bit is accepted on a cycle with DV & DR.
- DR  out  1  ready for a serial bit (combinational).
- Y  out  8  assembled word, registered.
- YV  out  1  Y valid, registered.
- YR  in  1  downstream ready; the word is consumed on YV & YR.
- CNT  out  3  counter-mode slot index of the next bit.
- M  in  1  mode: 0 = counter, 1 = addressed. Present only with DEMUX8_ADDR_EN.
- S  in  3  slot select in addressed mode. Present only with DEMUX8_ADDR_EN.

## Operation
- Internal state:
  - 8-bit shadow register holding the partial word.
  - 3-bit CNT.
  - 8-bit write mask (addressed mode only).
  - M_q, the registered mode.
- Counter mode, per accepted bit:
  - shadow[p] <= D, where p = CNT (MSB_FIRST=0) or 7-CNT (MSB_FIRST=1).
  - CNT <= CNT+1, wrapping 7->0.
- Word completion (the 8th accepted bit, i.e. CNT==7 on accept):
  - Y <= shadow with slot p replaced by D; YV <= 1; CNT <= 0.
  - The shadow is reused for the next word and is not cleared.
- Output handshake:
  - YV stays 1, and Y stays stable, until YV & YR.
  - After consumption YV <= 0, unless a new word completes in the same cycle; then YV stays 1 and Y takes the new word.
- Backpressure:
  - DR = !rst & !(completing & YV & !YR).
  - "completing" means the next accepted bit would finish a word.
  - Partial-word bits are always accepted; only the finishing bit stalls.
- Non-accepted cycles (DV=0, or DR=0): shadow, CNT and mask hold.

## Timing
- Reset (synchronous, rst high at a clk edge):
  - Y = 8'h00, YV = 0, CNT = 0.
  - Mask = 0, M_q = 0, shadow = 0.
  - DR = 0 while rst is high.
- Reset asserted mid-word: the partial word is discarded; the next accepted bit is slot 0 of a new word.
- Latency: YV rises on the clk edge that accepts the 8th bit, so it is visible the following cycle.
- Throughput: one bit per cycle. With YR held at 1, back-to-back words see YV high for one cycle every 8 cycles.
- DV=1 while DR=0: the bit is not taken. The source must hold D and DV.

## Configuration
- Macro: DEMUX8_ADDR_EN.
- Defined:
  - Ports M and S exist.
  - With M_q=1, each accepted bit is written to shadow[S] and mask[S] <= 1.
  - Rewriting an already-set slot overwrites the data and does not complete the word.
  - The word completes when (mask | onehot(S)) == 8'hFF on accept. Then Y is the merged word, YV <= 1, and mask <= 0.
  - The completion backpressure rule uses this condition.
  - CNT holds in addressed mode.
  - When M != M_q: that cycle DR = 0, CNT <= 0, mask <= 0, and M_q <= M. Any partial word is discarded.
- Undefined: no M or S ports; counter mode only; mask logic absent.

## Test plan
- MSB_FIRST=0, YR=1:
  - Stimulus: 1,0,0,0,0,1,0,1 on consecutive cycles.
  - Response: Y = 8'hA1 and YV = 1 for exactly one cycle, starting the cycle after the 8th bit; CNT back to 0.
- MSB_FIRST=1, same bit sequence -> Y = 8'h85.
- YR=0 with a word pending, then 8 more bits:
  - Bits 1-7 are accepted.
  - DR = 0 on bit 8 and Y holds its old value.
  - Raise YR: the old word is consumed, bit 8 is accepted on the same edge, and YV stays 1 with the new word.
- rst pulsed after 4 bits:
  - All outputs return to their reset values.
  - The next 8 bits form a clean word with no stale bits.
- DEMUX8_ADDR_EN, M=1:
  - S = 7,0,3,3,1,2,4,5,6 with D = 1,1,0,1,0,0,0,1,0.
  - The second write to slot 3 overwrites the first; Y = 8'hA9 after the S=6 write.
- DEMUX8_ADDR_EN: toggle M after 3 bits -> DR = 0 for one cycle, CNT = 0, mask = 0, and no YV pulse.

Source files
------------

// File: rtl/demux8x1_deser.sv
// demux8x1_deser - serial-to-parallel 1-to-8 demultiplexer.
//
// Receiving end of a mux8x1-based serializer. Each accepted serial bit
// (DV & DR) is written into one slot of an 8-bit shadow word. In counter
// mode an internal 3-bit counter picks the slot. The finished word is
// presented on Y with a YV/YR valid/ready handshake.
//
// Optional feature macro: DEMUX8_ADDR_EN
//   Adds ports M (mode) and S (slot select). With the registered mode at 1,
//   bits are written to shadow[S]. A write mask tracks which slots are
//   filled, and the word completes once all eight slots have been written.
//
// Parameters:
//   MSB_FIRST  0: first serial bit lands in Y[0]; 1: first bit lands in Y[7]
//
// Ports:
//   clk   in   rising-edge clock
//   rst   in   synchronous active-high reset
//   D     in   serial data bit
//   DV    in   D valid
//   DR    out  ready for a serial bit (combinational)
//   Y     out  assembled word (registered)
//   YV    out  Y valid (registered)
//   YR    in   downstream ready
//   CNT   out  counter-mode slot index of the next bit
//   M     in   mode, 0 counter / 1 addressed   (DEMUX8_ADDR_EN only)
//   S     in   slot select in addressed mode  (DEMUX8_ADDR_EN only)
module demux8x1_deser #(
  parameter int MSB_FIRST = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       D,
  input  logic       DV,
  output logic       DR,
  output logic [7:0] Y,
  output logic       YV,
  input  logic       YR,
  output logic [2:0] CNT
`ifdef DEMUX8_ADDR_EN
  ,
  input  logic       M,
  input  logic [2:0] S
`endif
);

  logic [7:0] shadow;
  logic [7:0] merged;
  logic [7:0] slot_oh;
  logic [2:0] slot;
  logic       completing;
  logic       mode_chg;
  logic       addr_mode;
  logic       accept;

`ifdef DEMUX8_ADDR_EN
  logic [7:0] mask;
  logic       m_q;

  assign addr_mode = m_q;
  // A mode change costs one dead cycle: the partial word is dropped and
  // no bit is taken while the mode register catches up.
  assign mode_chg  = (M != m_q);
`else
  assign addr_mode = 1'b0;
  assign mode_chg  = 1'b0;
`endif

  // Slot selection and the "this bit finishes the word" condition.
  always_comb begin
    slot       = (MSB_FIRST != 0) ? (3'd7 - CNT) : CNT;
    completing = (CNT == 3'd7);
`ifdef DEMUX8_ADDR_EN
    if (m_q) begin
      slot       = S;
      // Rewrites of an already-filled slot never complete the word.
      completing = ((mask | (8'b1 << S)) == 8'hFF);
    end
`endif
    slot_oh = 8'b1 << slot;
    merged  = (shadow & ~slot_oh) | ({8{D}} & slot_oh);
  end

  // Only the finishing bit stalls: it would overwrite a Y not yet consumed.
  assign DR     = !rst && !mode_chg && !(completing && YV && !YR);
  assign accept = DV && DR;

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow <= 8'h00;
      CNT    <= 3'd0;
      Y      <= 8'h00;
      YV     <= 1'b0;
`ifdef DEMUX8_ADDR_EN
      mask   <= 8'h00;
      m_q    <= 1'b0;
`endif
    end else begin
      // A word finishing on the consume edge keeps YV high with new data.
      if (accept && completing) begin
        Y  <= merged;
        YV <= 1'b1;
      end else if (YV && YR) begin
        YV <= 1'b0;
      end

      // Shadow is reused across words; every slot is rewritten before
      // the next completion, so it is never cleared.
      if (accept) shadow <= merged;

      if (accept && !addr_mode) CNT <= completing ? 3'd0 : CNT + 3'd1;

`ifdef DEMUX8_ADDR_EN
      if (accept && m_q) mask <= completing ? 8'h00 : (mask | slot_oh);
      if (mode_chg) begin
        CNT  <= 3'd0;
        mask <= 8'h00;
        m_q  <= M;
      end
`endif
    end
  end

endmodule
